// File: rtl/fetch_unit_s00_axis_loader.sv
// AXI4-Stream slave loader: decodes a length header, writes matrix A/B words to two BRAMs and hands off to the PE.
// Optional TSTRB checking is built when FETCH_LOADER_TSTRB_CHECK_EN is defined; otherwise err_strb is tied to 0.
module fetch_unit_s00_axis_loader #(
    parameter int BRAM_DEPTH           = 10,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic [BRAM_DEPTH-1:0]             mat_a_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   mat_a_din,
    output logic                              mat_a_wen,
    output logic [BRAM_DEPTH-1:0]             mat_b_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   mat_b_din,
    output logic                              mat_b_wen,
    output logic [15:0]                       a_len,
    output logic [15:0]                       b_len,
    output logic                              VALID_FU2PE,
    input  logic                              ACK_PE2FU,
    output logic                              err_early,
    output logic                              err_late,
    output logic                              err_len,
    output logic                              err_strb,
    input  logic                              err_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_DRAIN,
        S_HANDOFF
    } state_t;

    localparam logic [16:0] CAP = 17'd1 << BRAM_DEPTH;

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic        hs_wait;
    logic        beat, strb_bad;
    logic [15:0] hdr_a, hdr_b;
    logic        last_a, last_b;
    logic        wr_a, wr_b, hdr_load, cnt_clr, cnt_inc;
    logic        set_early, set_late, set_len, set_strb;

    assign beat   = S_AXIS_TVALID & S_AXIS_TREADY;
    assign hdr_a  = S_AXIS_TDATA[15:0];
    assign hdr_b  = S_AXIS_TDATA[31:16];
    assign last_a = ({1'b0, cnt} + 17'd1) == {1'b0, a_len};
    assign last_b = ({1'b0, cnt} + 17'd1) == {1'b0, b_len};

`ifdef FETCH_LOADER_TSTRB_CHECK_EN
    assign strb_bad = (S_AXIS_TSTRB != '1);
`else
    logic unused_tstrb;
    assign unused_tstrb = ^{S_AXIS_TSTRB, set_strb};
    assign strb_bad     = 1'b0;
`endif

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) state <= S_IDLE;
        else                 state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        hdr_load  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        set_early = 1'b0;
        set_late  = 1'b0;
        set_len   = 1'b0;
        set_strb  = 1'b0;
        case (state)
            S_IDLE: if (beat) begin
                hdr_load = 1'b1;
                cnt_clr  = 1'b1;
                if (strb_bad) begin
                    set_strb = 1'b1;
                    state_nx = S_AXIS_TLAST ? S_IDLE : S_DRAIN;
                end else if ({1'b0, hdr_a} > CAP || {1'b0, hdr_b} > CAP) begin
                    set_len  = 1'b1;
                    state_nx = S_AXIS_TLAST ? S_IDLE : S_DRAIN;
                end else if (hdr_a == '0 && hdr_b == '0) begin
                    if (S_AXIS_TLAST) state_nx = S_HANDOFF;
                    else begin
                        set_late = 1'b1;
                        state_nx = S_DRAIN;
                    end
                end else if (S_AXIS_TLAST) begin
                    set_early = 1'b1;
                    state_nx  = S_IDLE;
                end else begin
                    state_nx = (hdr_a == '0) ? S_LOAD_B : S_LOAD_A;
                end
            end
            S_LOAD_A: if (beat) begin
                if (strb_bad) begin
                    set_strb = 1'b1;
                    state_nx = S_AXIS_TLAST ? S_IDLE : S_DRAIN;
                end else begin
                    wr_a = 1'b1;
                    // With b_len == 0 the last A word is also the last word of the frame.
                    if (last_a && b_len == '0) begin
                        if (S_AXIS_TLAST) state_nx = S_HANDOFF;
                        else begin
                            set_late = 1'b1;
                            state_nx = S_DRAIN;
                        end
                    end else if (S_AXIS_TLAST) begin
                        set_early = 1'b1;
                        state_nx  = S_IDLE;
                    end else if (last_a) begin
                        cnt_clr  = 1'b1;
                        state_nx = S_LOAD_B;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_LOAD_B: if (beat) begin
                if (strb_bad) begin
                    set_strb = 1'b1;
                    state_nx = S_AXIS_TLAST ? S_IDLE : S_DRAIN;
                end else begin
                    wr_b = 1'b1;
                    if (last_b) begin
                        if (S_AXIS_TLAST) state_nx = S_HANDOFF;
                        else begin
                            set_late = 1'b1;
                            state_nx = S_DRAIN;
                        end
                    end else if (S_AXIS_TLAST) begin
                        set_early = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_DRAIN: if (beat && S_AXIS_TLAST) state_nx = S_IDLE;
            S_HANDOFF: if (VALID_FU2PE && ACK_PE2FU) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            S_AXIS_TREADY <= 1'b0;
            mat_a_addr    <= '0;
            mat_a_din     <= '0;
            mat_a_wen     <= 1'b0;
            mat_b_addr    <= '0;
            mat_b_din     <= '0;
            mat_b_wen     <= 1'b0;
            a_len         <= '0;
            b_len         <= '0;
            cnt           <= '0;
            hs_wait       <= 1'b0;
            VALID_FU2PE   <= 1'b0;
            err_early     <= 1'b0;
            err_late      <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            S_AXIS_TREADY <= (state_nx != S_HANDOFF);
            mat_a_wen     <= wr_a;
            mat_b_wen     <= wr_b;
            if (wr_a) begin
                mat_a_addr <= cnt[BRAM_DEPTH-1:0];
                mat_a_din  <= S_AXIS_TDATA;
            end
            if (wr_b) begin
                mat_b_addr <= cnt[BRAM_DEPTH-1:0];
                mat_b_din  <= S_AXIS_TDATA;
            end
            if (hdr_load) begin
                a_len <= hdr_a;
                b_len <= hdr_b;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 16'd1;
            // One idle HANDOFF cycle lets the final BRAM write land before VALID rises.
            hs_wait <= (state == S_HANDOFF);
            if (state == S_HANDOFF && VALID_FU2PE && ACK_PE2FU) VALID_FU2PE <= 1'b0;
            else if (state == S_HANDOFF && hs_wait)            VALID_FU2PE <= 1'b1;
            err_early <= set_early | (err_early & ~err_clr);
            err_late  <= set_late  | (err_late  & ~err_clr);
            err_len   <= set_len   | (err_len   & ~err_clr);
        end
    end

`ifdef FETCH_LOADER_TSTRB_CHECK_EN
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) err_strb <= 1'b0;
        else                 err_strb <= set_strb | (err_strb & ~err_clr);
    end
`else
    assign err_strb = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit_s00_axis_loader.sv
// Randomized bench for fetch_unit_s00_axis_loader: frames are scored against a frame-level model of the
// header/length/TLAST rules, with BRAM images rebuilt from the write ports.
module tb_fetch_unit_s00_axis_loader;

    localparam int DEPTH = 4;
    localparam int CAP   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_ack = 1'b0, s_err_clr = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = 4'hF;
    logic        tready, a_wen, b_wen, valid, err_early, err_late, err_len, err_strb;
    logic [DEPTH-1:0] a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic [15:0] a_len, b_len;

    fetch_unit_s00_axis_loader #(.BRAM_DEPTH(DEPTH), .C_S_AXIS_TDATA_WIDTH(32)) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(tready), .S_AXIS_TDATA(s_tdata),
        .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
        .mat_a_addr(a_addr), .mat_a_din(a_din), .mat_a_wen(a_wen),
        .mat_b_addr(b_addr), .mat_b_din(b_din), .mat_b_wen(b_wen),
        .a_len(a_len), .b_len(b_len), .VALID_FU2PE(valid), .ACK_PE2FU(s_ack),
        .err_early(err_early), .err_late(err_late), .err_len(err_len), .err_strb(err_strb),
        .err_clr(s_err_clr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_errors = 0, wr_cnt = 0;
    logic [31:0] dut_a[CAP], dut_b[CAP], exp_a[CAP], exp_b[CAP];
    logic [31:0] bd[$];
    logic        bl[$];
    logic        e_early = 1'b0, e_late = 1'b0, e_len = 1'b0;
    logic [15:0] x_alen, x_blen;
    int          m_wr;
    bit          m_ho;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        check("watchdog", 0, 1);
        finish_sim();
    end

    // Rebuild BRAM contents from the write ports, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_wen) begin
            dut_a[a_addr] = a_din;
            wr_cnt++;
        end
        if (b_wen) begin
            dut_b[b_addr] = b_din;
            wr_cnt++;
        end
        if (a_wen || b_wen) check("one_wen", 32'(a_wen & b_wen), 0);
    end

    task automatic send_beat(input logic [31:0] d, input logic l, input int gap);
        bit ok;
        int n;
        s_tvalid = 1'b0;
        repeat (gap) tick();
        s_tdata  = d;
        s_tlast  = l;
        s_tstrb  = 4'($urandom);
`ifdef FETCH_LOADER_TSTRB_CHECK_EN
        s_tstrb  = 4'hF;
`endif
        s_tvalid = 1'b1;
        n = 0;
        do begin
            ok = tready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            check("accept_timeout", 0, 1);
            finish_sim();
        end
    endtask

    // Frame-level reference: walks the beat list applying the header/length/TLAST rules.
    task automatic model_frame();
        logic [31:0] h;
        int la, lb, tot;
        h = bd[0];
        la = int'(h[15:0]);
        lb = int'(h[31:16]);
        tot = la + lb;
        x_alen = h[15:0];
        x_blen = h[31:16];
        m_wr = 0;
        m_ho = 0;
        if (la > CAP || lb > CAP) e_len = 1'b1;
        else if (tot == 0) begin
            if (bl[0]) m_ho = 1;
            else       e_late = 1'b1;
        end else if (bl[0]) e_early = 1'b1;
        else begin
            for (int k = 0; k < tot && k + 1 < bd.size(); k++) begin
                if (k < la) exp_a[k] = bd[k+1];
                else        exp_b[k-la] = bd[k+1];
                m_wr++;
                if (k == tot - 1) begin
                    if (bl[k+1]) m_ho = 1;
                    else         e_late = 1'b1;
                end else if (bl[k+1]) begin
                    e_early = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic mk_hdr(input int a, input int b, input logic l);
        bd.delete();
        bl.delete();
        bd.push_back({16'(b), 16'(a)});
        bl.push_back(l);
    endtask

    task automatic mk_good(input int a, input int b);
        mk_hdr(a, b, (a + b == 0));
        for (int k = 0; k < a + b; k++) begin
            bd.push_back($urandom);
            bl.push_back(k == a + b - 1);
        end
    endtask

    task automatic mk_early(input int a, input int b);
        int last;
        last = int'($urandom_range(0, a + b - 1)) - 1;
        mk_hdr(a, b, (last == -1));
        for (int k = 0; k <= last; k++) begin
            bd.push_back($urandom);
            bl.push_back(k == last);
        end
    endtask

    task automatic mk_late(input int a, input int b, input int junk);
        mk_hdr(a, b, 1'b0);
        for (int k = 0; k < a + b + junk; k++) begin
            bd.push_back($urandom);
            bl.push_back(k == a + b + junk - 1);
        end
    endtask

    task automatic mk_len(input int a, input int b, input int junk);
        mk_hdr(a, b, (junk == 0));
        for (int k = 0; k < junk; k++) begin
            bd.push_back($urandom);
            bl.push_back(k == junk - 1);
        end
    endtask

    task automatic run_frame(input int gapmax, input int ackdly);
        int w0, hi;
        w0 = wr_cnt;
        model_frame();
        foreach (bd[i]) send_beat(bd[i], bl[i], int'($urandom_range(0, gapmax)));
        s_tvalid = 1'b0;
        if (m_ho) begin
            check("valid_at_accept", 32'(valid), 0);
            tick();
            check("valid_plus1", 32'(valid), 0);
            tick();
            check("valid_plus2", 32'(valid), 1);
            check("tready_handoff", 32'(tready), 0);
            hi = 0;
            for (int d = 0; d < ackdly; d++) begin
                tick();
                if (valid && !tready) hi++;
            end
            check("valid_hold", hi, ackdly);
            s_ack = 1'b1;
            tick();
            s_ack = 1'b0;
            check("valid_drop", 32'(valid), 0);
        end else begin
            repeat (3) tick();
            check("valid_none", 32'(valid), 0);
        end
        check("tready_idle", 32'(tready), 1);
        check("wr_count", wr_cnt - w0, m_wr);
        check("a_len", 32'(a_len), 32'(x_alen));
        check("b_len", 32'(b_len), 32'(x_blen));
        check("err_flags", 32'({err_early, err_late, err_len}), 32'({e_early, e_late, e_len}));
        check("err_strb", 32'(err_strb), 0);
        for (int i = 0; i < CAP; i++) begin
            check("mem_a", dut_a[i], exp_a[i]);
            check("mem_b", dut_b[i], exp_b[i]);
        end
    endtask

    task automatic clr_errs();
        s_err_clr = 1'b1;
        tick();
        s_err_clr = 1'b0;
        e_early = 1'b0;
        e_late  = 1'b0;
        e_len   = 1'b0;
        check("err_clr", 32'({err_early, err_late, err_len, err_strb}), 0);
    endtask

    task automatic ack_idle();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        check("ack_ignored_valid", 32'(valid), 0);
        check("ack_ignored_tready", 32'(tready), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({tready, a_wen, b_wen, valid, err_early, err_late, err_len, err_strb}), 0);
        check({tag, "_addr"}, 32'({a_addr, b_addr}), 0);
        check({tag, "_din"}, a_din | b_din, 0);
        check({tag, "_len"}, {b_len, a_len}, 0);
    endtask

    initial begin
        int kind, a, b, w0;
        for (int i = 0; i < CAP; i++) begin
            dut_a[i] = '0; dut_b[i] = '0; exp_a[i] = '0; exp_b[i] = '0;
        end
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Nominal 3+2 frame, continuous TVALID, immediate ACK.
        mk_good(3, 2);
        for (int k = 1; k <= 5; k++) bd[k] = 32'(k);
        run_frame(0, 0);
        // Same frame with gaps and a 10-cycle ACK delay.
        mk_good(3, 2);
        for (int k = 1; k <= 5; k++) bd[k] = 32'(k);
        run_frame(3, 10);
        // TLAST on the third of four data words.
        mk_hdr(2, 2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bd.push_back(32'h100 + 32'(k));
            bl.push_back(k == 2);
        end
        run_frame(1, 0);
        mk_good(2, 2);
        run_frame(1, 2);
        clr_errs();
        // Missing TLAST, three junk words.
        mk_late(1, 1, 3);
        run_frame(1, 0);
        clr_errs();
        // Length over capacity, drained.
        mk_len(17, 0, 3);
        run_frame(1, 0);
        mk_len(0, 17, 0);
        run_frame(0, 0);
        clr_errs();
        // Boundaries: empty frame and full capacity.
        mk_good(0, 0);
        run_frame(0, 1);
        mk_good(CAP, CAP);
        run_frame(1, 3);
        mk_good(0, 4);
        run_frame(0, 0);

        // Reset after two of three A words.
        w0 = wr_cnt;
        mk_good(3, 2);
        send_beat(bd[0], 1'b0, 0);
        send_beat(bd[1], 1'b0, 0);
        send_beat(bd[2], 1'b0, 0);
        s_tvalid = 1'b0;
        tick();
        tick();
        exp_a[0] = bd[1];
        exp_a[1] = bd[2];
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("wr_before_rst", wr_cnt - w0, 2);
        e_early = 1'b0; e_late = 1'b0; e_len = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mk_good(3, 2);
        run_frame(0, 1);

        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 4));
            a = int'($urandom_range(0, CAP));
            b = int'($urandom_range(0, CAP));
            case (kind)
                0, 1: mk_good(a, b);
                2: begin
                    if (a + b == 0) a = 1;
                    mk_early(a, b);
                end
                3: mk_late(a, b, int'($urandom_range(1, 3)));
                default: begin
                    if ($urandom_range(0, 1) == 0) mk_len(CAP + 1 + int'($urandom_range(0, 100)), b, int'($urandom_range(0, 3)));
                    else                           mk_len(a, CAP + 1 + int'($urandom_range(0, 100)), int'($urandom_range(0, 3)));
                end
            endcase
            run_frame(2, int'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) clr_errs();
            if ($urandom_range(0, 3) == 0) ack_idle();
        end
        finish_sim();
    end

endmodule

// File: doc/fetch_unit_s00_axis_loader.md
Name: fetch_unit_s00_axis_loader

Overview:
- AXI4-Stream slave front end of the fetch unit.
- Receives a framed operand stream: one header word, then matrix A words, then matrix B words.
- Writes A and B into two operand BRAMs and raises VALID_FU2PE to the processing element.
- Blocks further input until the PE acknowledges. Upstream of the PE; the result path back out goes through the M00 AXIS stage.

Parameters:
- BRAM_DEPTH, 10, address width of each operand BRAM; capacity 2^BRAM_DEPTH words.
- C_S_AXIS_TDATA_WIDTH, 32, stream data width; fixed at 32 for header decoding.

Ports:
- S_AXIS_ACLK  in  1  clock.
- S_AXIS_ARESETN  in  1  reset; one clock; reset is asynchronous and active-low.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  beat ready.
- S_AXIS_TDATA  in  32  beat data.
- S_AXIS_TSTRB  in  4  byte strobes.
- S_AXIS_TLAST  in  1  frame end.
- mat_a_addr  out  BRAM_DEPTH  A write address.
- mat_a_din  out  32  A write data.
- mat_a_wen  out  1  A write enable.
- mat_b_addr  out  BRAM_DEPTH  B write address.
- mat_b_din  out  32  B write data.
- mat_b_wen  out  1  B write enable.
- a_len  out  16  registered A word count from header.
- b_len  out  16  registered B word count from header.
- VALID_FU2PE  out  1  operands loaded; held until ACK_PE2FU.
- ACK_PE2FU  in  1  PE has consumed the operands.
- err_early  out  1  sticky: TLAST before the expected last word.
- err_late  out  1  sticky: no TLAST on the expected last word.
- err_len  out  1  sticky: header length exceeds capacity.
- err_clr  in  1  synchronous clear of all sticky errors.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0, including TREADY, wen, addr, din, a_len, b_len, VALID_FU2PE and the error flags.
- Beat accepted when TVALID and TREADY are both high at a rising edge.
- TREADY = 1 in IDLE, LOAD_A, LOAD_B and DRAIN; 0 in HANDOFF.
- Header decode: a_len = TDATA[15:0], b_len = TDATA[31:16].
- IDLE, header accepted:
  - Either length > 2^BRAM_DEPTH -> set err_len; go to DRAIN, or to IDLE if TLAST is on the header.
  - Both lengths 0 with TLAST -> HANDOFF.
  - Both lengths 0 without TLAST -> err_late, DRAIN.
  - TLAST with a nonzero length -> err_early, IDLE.
  - a_len = 0 -> LOAD_B.
  - Otherwise -> LOAD_A.
- LOAD_A: word k is written to A address k, k = 0..a_len-1.
  - After the last A word: go to LOAD_B if b_len > 0; otherwise apply the last-word TLAST rules.
- LOAD_B: same addressing into B.
  - The last B word is the expected final word of the frame.
- TLAST on the expected final word -> HANDOFF.
- TLAST on any earlier word -> err_early, IDLE, no handoff. Words already written remain in BRAM.
- Expected final word without TLAST -> err_late, DRAIN.
- Write timing:
  - addr, din and wen are registered, so wen is high for exactly one cycle, one cycle after acceptance.
  - Only one BRAM enable is active per cycle.
- HANDOFF:
  - VALID_FU2PE rises 2 cycles after the final beat is accepted, so the last write completes first.
  - VALID_FU2PE stays high until ACK_PE2FU is sampled high; it drops on the next cycle and the state returns to IDLE.
  - ACK_PE2FU outside HANDOFF is ignored.
- DRAIN: accepted beats are discarded; TLAST -> IDLE.
- a_len and b_len update only when a header is accepted and hold until the next header.
- Sticky errors:
  - Set only by the events above.
  - err_clr clears them; if a set and err_clr occur in the same cycle, the set wins.
- Reset mid-frame: state, counters and VALID_FU2PE go to 0 immediately. The next accepted beat is treated as a header.

Optional Feature:
- Macro: FETCH_LOADER_TSTRB_CHECK_EN.
- Defined: any accepted header or data beat with TSTRB != 4'hF sets err_strb.
  - err_strb is an extra sticky output, cleared by err_clr.
  - The beat is not written; the state goes to DRAIN, or to IDLE if that beat has TLAST.
- Not defined: TSTRB is ignored, and err_strb exists but is tied to 0.

Test Plan:
- Header 0x0002_0003, then A = 1,2,3 and B = 4,5 with TLAST on 5, TVALID continuous -> A[0..2] = 1,2,3; B[0..1] = 4,5. VALID_FU2PE rises 2 cycles after the beat carrying 5; TREADY = 0 until ACK_PE2FU, then IDLE.
- Same frame with TVALID gaps, TLAST on the B word, and ACK_PE2FU delayed 10 cycles -> identical BRAM contents; VALID_FU2PE held high 10 cycles; no extra beats accepted.
- Header 0x0002_0002 with TLAST on the 3rd data word -> err_early = 1, IDLE, VALID_FU2PE stays 0. Next good frame loads normally; err_clr pulse clears err_early.
- Header 0x0001_0001, 2 data words without TLAST, then 3 junk words, TLAST on the last junk word -> err_late = 1; junk not written (no wen); state IDLE afterwards.
- BRAM_DEPTH = 4, header 0x0000_0011 -> err_len = 1; following words drained until TLAST; no writes.
- Assert reset after 2 of 3 A words -> all outputs 0 immediately. After release, a full frame loads correctly, starting at address 0.
